// File: rtl/pc_fetch_gen.sv
// Fetch-PC generator with split request/response memory interface.
// Tracks in-flight fetch PCs in a FIFO and drops stale responses after a redirect.
module pc_fetch_gen #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned INST_BYTES = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned MAX_INFLIGHT = 2,
  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_if,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              req_valid,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              req_ready,
  input  logic              rsp_valid,
  input  logic [INST_W-1:0] rsp_data,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [INST_W-1:0] inst,
  output logic [CNT_W-1:0]  inflight,
  output logic              proto_err
);

  localparam int unsigned PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              en_q;
  logic [ADDR_W-1:0] fifo_q [MAX_INFLIGHT];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              inst_valid_q;
  logic [ADDR_W-1:0] inst_pc_q;
  logic [INST_W-1:0] inst_q;
  logic              proto_err_q;

  logic [CNT_W:0]    total;
  logic              accept, push, pop, flush, deliver, err_set;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // One extra bit so the sum never wraps before the limit compare.
  assign total     = {1'b0, fifo_cnt_q} + {1'b0, drop_cnt_q};
  assign req_valid = en_q & ~stall_if & ~redirect_valid & (total < (CNT_W+1)'(MAX_INFLIGHT));
  assign req_addr  = pc_q;
  assign accept    = req_valid & req_ready;

  always_comb begin
    pc_d       = pc_q;
    fifo_cnt_d = fifo_cnt_q;
    drop_cnt_d = drop_cnt_q;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    deliver    = 1'b0;
    err_set    = 1'b0;
    if (redirect_valid) begin
      // Everything outstanding becomes stale; a same-cycle response consumes one of them.
      pc_d       = redirect_pc;
      flush      = 1'b1;
      fifo_cnt_d = '0;
      if (rsp_valid && total == '0) begin
        err_set    = 1'b1;
        drop_cnt_d = '0;
      end else if (rsp_valid) begin
        drop_cnt_d = CNT_W'(total - (CNT_W+1)'(1));
      end else begin
        drop_cnt_d = CNT_W'(total);
      end
    end else begin
      if (accept) begin
        push = 1'b1;
        pc_d = pc_q + ADDR_W'(INST_BYTES);
      end
      if (rsp_valid) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end else if (fifo_cnt_q != '0) begin
          pop     = 1'b1;
          deliver = 1'b1;
        end else begin
          err_set = 1'b1;
        end
      end
      fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q         <= RESET_PC;
      en_q         <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      drop_cnt_q   <= '0;
      inst_valid_q <= 1'b0;
      inst_pc_q    <= '0;
      inst_q       <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      en_q         <= 1'b1;
      pc_q         <= pc_d;
      fifo_cnt_q   <= fifo_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      inst_valid_q <= deliver;
      proto_err_q  <= proto_err_q | err_set;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
        if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      if (deliver) begin
        inst_pc_q <= fifo_q[rd_ptr_q];
        inst_q    <= rsp_data;
      end
    end
  end

  // PC storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= pc_q;
  end

  assign inst_valid = inst_valid_q;
  assign inst_pc    = inst_pc_q;
  assign inst       = inst_q;
  assign inflight   = CNT_W'(total);
  assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Directed, table-driven bench for pc_fetch_gen, plus async-reset and PC-wrap sequences.
module tb_pc_fetch_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_if = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst;
  logic [1:0]  inflight;
  logic        proto_err;

  logic        w_rst = 1'b0;
  logic        w_req_valid;
  logic [7:0]  w_req_addr;
  logic        w_inst_valid;
  logic [7:0]  w_inst_pc;
  logic [31:0] w_inst;
  logic [2:0]  w_inflight;
  logic        w_proto_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pc_fetch_gen u_dut (
    .clk            (clk),
    .rst            (rst),
    .stall_if       (stall_if),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .inst_valid     (inst_valid),
    .inst_pc        (inst_pc),
    .inst           (inst),
    .inflight       (inflight),
    .proto_err      (proto_err)
  );

  pc_fetch_gen #(
    .ADDR_W       (8),
    .RESET_PC     (8'hFC),
    .MAX_INFLIGHT (4)
  ) u_wrap (
    .clk            (clk),
    .rst            (w_rst),
    .stall_if       (1'b0),
    .redirect_valid (1'b0),
    .redirect_pc    (8'h00),
    .req_valid      (w_req_valid),
    .req_addr       (w_req_addr),
    .req_ready      (1'b1),
    .rsp_valid      (1'b0),
    .rsp_data       (32'h0),
    .inst_valid     (w_inst_valid),
    .inst_pc        (w_inst_pc),
    .inst           (w_inst),
    .inflight       (w_inflight),
    .proto_err      (w_proto_err)
  );

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] redir_pc;
    logic        ready;
    logic        rsp;
    logic [31:0] rsp_data;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_ipc;
    logic [31:0] e_inst;
    logic [1:0]  e_infl;
    logic        e_perr;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    // stall redir redir_pc ready rsp rsp_data | rv addr iv ipc inst infl perr
    vecs[0]  = '{0, 0, 32'h0,   1, 0, 32'h0,        0, 32'h0,   0, 32'h0,   32'h0,        2'd0, 0};
    vecs[1]  = '{0, 0, 32'h0,   1, 0, 32'h0,        1, 32'h0,   0, 32'h0,   32'h0,        2'd0, 0};
    vecs[2]  = '{0, 0, 32'h0,   1, 1, 32'hA0000000, 1, 32'h4,   0, 32'h0,   32'h0,        2'd1, 0};
    vecs[3]  = '{0, 0, 32'h0,   1, 1, 32'hA0000004, 1, 32'h8,   1, 32'h0,   32'hA0000000, 2'd1, 0};
    vecs[4]  = '{1, 0, 32'h0,   1, 1, 32'hA0000008, 0, 32'hC,   1, 32'h4,   32'hA0000004, 2'd1, 0};
    vecs[5]  = '{1, 0, 32'h0,   1, 0, 32'h0,        0, 32'hC,   1, 32'h8,   32'hA0000008, 2'd0, 0};
    vecs[6]  = '{1, 0, 32'h0,   1, 0, 32'h0,        0, 32'hC,   0, 32'h8,   32'hA0000008, 2'd0, 0};
    vecs[7]  = '{0, 0, 32'h0,   1, 0, 32'h0,        1, 32'hC,   0, 32'h8,   32'hA0000008, 2'd0, 0};
    vecs[8]  = '{0, 0, 32'h0,   1, 0, 32'h0,        1, 32'h10,  0, 32'h8,   32'hA0000008, 2'd1, 0};
    vecs[9]  = '{0, 1, 32'h100, 1, 0, 32'h0,        0, 32'h14,  0, 32'h8,   32'hA0000008, 2'd2, 0};
    vecs[10] = '{0, 0, 32'h0,   1, 1, 32'hDEAD000C, 0, 32'h100, 0, 32'h8,   32'hA0000008, 2'd2, 0};
    vecs[11] = '{0, 0, 32'h0,   1, 1, 32'hDEAD0010, 1, 32'h100, 0, 32'h8,   32'hA0000008, 2'd1, 0};
    vecs[12] = '{0, 0, 32'h0,   1, 1, 32'hA0000100, 1, 32'h104, 0, 32'h8,   32'hA0000008, 2'd1, 0};
    vecs[13] = '{0, 0, 32'h0,   1, 0, 32'h0,        1, 32'h108, 1, 32'h100, 32'hA0000100, 2'd1, 0};
    vecs[14] = '{0, 1, 32'h200, 1, 1, 32'hA0000104, 0, 32'h10C, 0, 32'h100, 32'hA0000100, 2'd2, 0};
    vecs[15] = '{0, 0, 32'h0,   1, 1, 32'hDEAD0108, 1, 32'h200, 0, 32'h100, 32'hA0000100, 2'd1, 0};
    vecs[16] = '{0, 0, 32'h0,   0, 1, 32'hA0000200, 1, 32'h204, 0, 32'h100, 32'hA0000100, 2'd1, 0};
    vecs[17] = '{0, 0, 32'h0,   0, 0, 32'h0,        1, 32'h204, 1, 32'h200, 32'hA0000200, 2'd0, 0};
    vecs[18] = '{0, 1, 32'h300, 0, 0, 32'h0,        0, 32'h204, 0, 32'h200, 32'hA0000200, 2'd0, 0};
    vecs[19] = '{0, 1, 32'h400, 0, 0, 32'h0,        0, 32'h300, 0, 32'h200, 32'hA0000200, 2'd0, 0};
    vecs[20] = '{0, 0, 32'h0,   0, 1, 32'h12345678, 1, 32'h400, 0, 32'h200, 32'hA0000200, 2'd0, 0};
    vecs[21] = '{0, 0, 32'h0,   1, 0, 32'h0,        1, 32'h400, 0, 32'h200, 32'hA0000200, 2'd0, 1};
    vecs[22] = '{0, 0, 32'h0,   1, 1, 32'hA0000400, 1, 32'h404, 0, 32'h200, 32'hA0000200, 2'd1, 1};
    vecs[23] = '{0, 0, 32'h0,   1, 0, 32'h0,        1, 32'h408, 1, 32'h400, 32'hA0000400, 2'd1, 1};

    #2;
    check("reset req_valid", {31'b0, req_valid}, 32'h0);
    check("reset inst_valid", {31'b0, inst_valid}, 32'h0);
    check("reset inflight", {30'b0, inflight}, 32'h0);
    check("reset proto_err", {31'b0, proto_err}, 32'h0);

    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NV; i++) begin
      stall_if       = vecs[i].stall;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].redir_pc;
      req_ready      = vecs[i].ready;
      rsp_valid      = vecs[i].rsp;
      rsp_data       = vecs[i].rsp_data;
      #1;
      check($sformatf("v%0d req_valid", i), {31'b0, req_valid}, {31'b0, vecs[i].e_rv});
      check($sformatf("v%0d req_addr", i), req_addr, vecs[i].e_addr);
      check($sformatf("v%0d inst_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].e_iv});
      check($sformatf("v%0d inst_pc", i), inst_pc, vecs[i].e_ipc);
      check($sformatf("v%0d inst", i), inst, vecs[i].e_inst);
      check($sformatf("v%0d inflight", i), {30'b0, inflight}, {30'b0, vecs[i].e_infl});
      check($sformatf("v%0d proto_err", i), {31'b0, proto_err}, {31'b0, vecs[i].e_perr});
      if (i < NV - 1) @(negedge clk);
    end

    // Mid-cycle reset: outputs must clear without waiting for a clock edge.
    #2 rst = 1'b0;
    #1;
    check("async req_valid", {31'b0, req_valid}, 32'h0);
    check("async req_addr", req_addr, 32'h0);
    check("async inst_valid", {31'b0, inst_valid}, 32'h0);
    check("async inst_pc", inst_pc, 32'h0);
    check("async inst", inst, 32'h0);
    check("async inflight", {30'b0, inflight}, 32'h0);
    check("async proto_err", {31'b0, proto_err}, 32'h0);

    // 8-bit PC wraps from FC to 00.
    @(negedge clk);
    w_rst = 1'b1;
    #1;
    check("wrap c0 req_valid", {31'b0, w_req_valid}, 32'h0);
    check("wrap c0 req_addr", {24'b0, w_req_addr}, 32'hFC);
    @(negedge clk); #1;
    check("wrap c1 req_valid", {31'b0, w_req_valid}, 32'h1);
    check("wrap c1 req_addr", {24'b0, w_req_addr}, 32'hFC);
    @(negedge clk); #1;
    check("wrap c2 req_addr", {24'b0, w_req_addr}, 32'h00);
    @(negedge clk); #1;
    check("wrap c3 req_addr", {24'b0, w_req_addr}, 32'h04);
    check("wrap c3 inflight", {29'b0, w_inflight}, 32'h2);
    check("wrap c3 proto_err", {31'b0, w_proto_err}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
